// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and width helpers for the round-robin FIFO drain arbiter
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: first set bit of req searching ptr, ptr+1, ... modulo N
//   req   : request vector
//   ptr   : search start index
//   idx   : index of the first request found
//   found : any request set
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] idx,
    output logic         found
);

    // Walk offsets from farthest to nearest so the nearest hit is written last.
    always_comb begin
        idx   = '0;
        found = |req;
        for (int k = N - 1; k >= 0; k--)
            if (req[(int'(ptr) + k) % N]) idx = W'((int'(ptr) + k) % N);
    end

endmodule

// File: rtl/fifo_rr_drain_arbiter.sv
// fifo_rr_drain_arbiter: round-robin burst drain of N_PORTS FIFOs onto one registered valid/ready channel
//   clk, rst        : clock, asynchronous active-high reset
//   pndng           : per-FIFO not-empty flags
//   fifo_dout       : FIFO head words, port i at [i*BITS +: BITS]
//   pop             : one-hot-or-zero pop pulses to the FIFOs
//   out_data/out_src: registered word and the port it came from
//   out_valid/ready : output handshake
//   gnt             : one-hot current grant, zero while arbitrating
//   busy            : burst in progress or a word is held
module fifo_rr_drain_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_PORTS   = 4,
    parameter int BITS      = 16,
    parameter int MAX_BURST = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_PORTS-1:0]         pndng,
    input  logic [N_PORTS*BITS-1:0]    fifo_dout,
    output logic [N_PORTS-1:0]         pop,
    output logic [BITS-1:0]            out_data,
    output logic [$clog2(N_PORTS)-1:0] out_src,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [N_PORTS-1:0]         gnt,
    output logic                       busy
);

    localparam int IW = idx_w(N_PORTS);
    localparam int CW = cnt_w(MAX_BURST);

    state_t          state;
    logic [IW-1:0]   g, rr_ptr, pick;
    logic [CW-1:0]   burst_cnt;
    logic            found, slot_free, do_pop, done;

    rr_pick #(.N(N_PORTS), .W(IW)) u_pick (
        .req  (pndng),
        .ptr  (rr_ptr),
        .idx  (pick),
        .found(found)
    );

    // A word may be captured whenever the output register is empty or being accepted.
    assign slot_free = !out_valid || out_ready;
    assign do_pop    = state == BURST && pndng[g] && slot_free;
    // The burst ends on its last allowed pop, or once the granted FIFO has run dry.
    assign done      = state == BURST && (!pndng[g] || (do_pop && burst_cnt == CW'(MAX_BURST - 1)));
    assign pop       = do_pop ? {{(N_PORTS-1){1'b0}}, 1'b1} << g : '0;
    assign busy      = state == BURST || out_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= '0;
            g         <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
        end else begin
            if (do_pop) begin
                out_data  <= fifo_dout[g*BITS +: BITS];
                out_src   <= g;
                out_valid <= 1'b1;
                burst_cnt <= CW'(burst_cnt + 1'b1);
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (state == IDLE && found) begin
                state     <= BURST;
                gnt       <= {{(N_PORTS-1){1'b0}}, 1'b1} << pick;
                g         <= pick;
                burst_cnt <= '0;
            end
            if (done) begin
                state  <= IDLE;
                gnt    <= '0;
                rr_ptr <= (g == IW'(N_PORTS - 1)) ? '0 : IW'(g + 1'b1);
            end
        end
    end

endmodule

// File: tb/tb_fifo_rr_drain_arbiter.sv
// tb_fifo_rr_drain_arbiter: scoreboard bench with behavioural source FIFOs for fifo_rr_drain_arbiter
module tb_fifo_rr_drain_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  pndng = '0;
    logic [63:0] fifo_dout = '0;
    logic [3:0]  pop;
    logic [15:0] out_data;
    logic [1:0]  out_src;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  gnt;
    logic        busy;

    logic [15:0] q [4][$];
    logic [17:0] sb [$];
    logic [3:0]  pop_s;
    logic [31:0] hist;
    int          hist_port;
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    fifo_rr_drain_arbiter #(.N_PORTS(4), .BITS(16), .MAX_BURST(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .pndng    (pndng),
        .fifo_dout(fifo_dout),
        .pop      (pop),
        .out_data (out_data),
        .out_src  (out_src),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .gnt      (gnt),
        .busy     (busy)
    );

    task automatic refresh();
        for (int i = 0; i < 4; i++) begin
            pndng[i]            = q[i].size() != 0;
            fifo_dout[i*16 +: 16] = (q[i].size() != 0) ? q[i][0] : 16'h0;
        end
    endtask

    task automatic push(input int p, input logic [15:0] v);
        q[p].push_back(v);
        sb.push_back({2'(p), v});
    endtask

    // One clock: monitor at negedge, apply FIFO pops just after the rising edge.
    task automatic step();
        logic [17:0] e;
        @(negedge clk);
        pop_s = pop;
        vectors++;
        if ($countones(pop_s) > 1) begin
            miscompares++;
            $display("FAIL pop_onehot got=%b", pop_s);
        end
        if (out_valid && out_ready) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_word got src=%0d data=%h", out_src, out_data);
            end else begin
                e = sb.pop_front();
                if ({out_src, out_data} !== e) begin
                    miscompares++;
                    $display("FAIL out_word got src=%0d data=%h exp src=%0d data=%h",
                             out_src, out_data, e[17:16], e[15:0]);
                end
            end
        end
        hist = {hist[30:0], pop_s[hist_port]};
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++)
            if (pop_s[i]) begin
                vectors++;
                if (q[i].size() == 0) begin
                    miscompares++;
                    $display("FAIL pop_empty port=%0d got pop=%b exp no pop", i, pop_s);
                end else begin
                    void'(q[i].pop_front());
                end
            end
        refresh();
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((sb.size() != 0 || q[0].size() != 0 || q[1].size() != 0 || q[2].size() != 0 ||
                q[3].size() != 0 || busy) && n < 300) begin
            step();
            n++;
        end
        vectors++;
        if (n >= 300) begin
            miscompares++;
            $display("FAIL %s_timeout got %0d words left exp 0", name, sb.size());
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic check_hist(input string name, input logic [31:0] exp);
        for (int i = 0; i < 32; i++)
            if (hist != 0 && !hist[0]) hist = hist >> 1;
        vectors++;
        if (hist !== exp) begin
            miscompares++;
            $display("FAIL %s_pop_pattern got=%b exp=%b", name, hist, exp);
        end
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        vectors++;
        if ({gnt, pop, out_valid, out_data, out_src, busy} !== '0) begin
            miscompares++;
            $display("FAIL reset_state got gnt=%b pop=%b v=%b d=%h s=%0d busy=%b exp all zero",
                     gnt, pop, out_valid, out_data, out_src, busy);
        end
        rst = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        int n = 0;
        out_ready = 1'b0;
        q[0].push_back(16'h00A0);
        q[0].push_back(16'h00A1);
        q[0].push_back(16'h00A2);
        refresh();
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        vectors++;
        if (!out_valid || out_data !== 16'h00A0) begin
            miscompares++;
            $display("FAIL midrst_capture got v=%b d=%h exp v=1 d=00a0", out_valid, out_data);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if ({gnt, pop, out_valid, out_data, out_src, busy} !== '0) begin
            miscompares++;
            $display("FAIL midrst_async got gnt=%b pop=%b v=%b d=%h busy=%b exp all zero",
                     gnt, pop, out_valid, out_data, busy);
        end
        vectors++;
        if (q[0].size() != 2) begin
            miscompares++;
            $display("FAIL midrst_fifo_left got=%0d exp=2", q[0].size());
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        sb.push_back({2'd0, 16'h00A1});
        sb.push_back({2'd0, 16'h00A2});
        drain("midrst");
    endtask

    task automatic test_single_source();
        do_reset();
        out_ready = 1'b1;
        hist_port = 2;
        hist = '0;
        for (int k = 1; k <= 6; k++) push(2, 16'(k));
        refresh();
        drain("single");
        check_hist("single", 32'b1111011);
    endtask

    task automatic test_fairness();
        do_reset();
        out_ready = 1'b1;
        for (int p = 0; p < 4; p++)
            for (int k = 0; k < 8; k++) q[p].push_back(16'(256 * p + k));
        for (int r = 0; r < 2; r++)
            for (int p = 0; p < 4; p++)
                for (int k = 0; k < 4; k++) sb.push_back({2'(p), 16'(256 * p + 4 * r + k)});
        refresh();
        drain("fair");
    endtask

    task automatic test_backpressure();
        int n = 0;
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) push(1, 16'(16 + k));
        refresh();
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        out_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            vectors++;
            if (!out_valid || out_data !== 16'h0010 || pop !== 4'b0000 || gnt !== 4'b0010 ||
                q[1].size() != 4 || !busy) begin
                miscompares++;
                $display("FAIL stall_hold cyc=%0d got v=%b d=%h pop=%b gnt=%b left=%0d exp v=1 d=0010 pop=0000 gnt=0010 left=4",
                         c, out_valid, out_data, pop, gnt, q[1].size());
            end
        end
        out_ready = 1'b1;
        drain("bp");
    endtask

    task automatic test_wrap();
        int n = 0;
        do_reset();
        out_ready = 1'b1;
        push(2, 16'h0C0C);
        refresh();
        drain("wrap_pre");
        push(3, 16'h0B0B);
        push(0, 16'h0A0A);
        refresh();
        while (gnt == 4'b0000 && n < 20) begin
            step();
            n++;
        end
        vectors++;
        if (gnt !== 4'b1000) begin
            miscompares++;
            $display("FAIL wrap_grant got=%b exp=1000", gnt);
        end
        drain("wrap");
    endtask

    task automatic test_drain_early();
        do_reset();
        out_ready = 1'b1;
        hist_port = 1;
        hist = '0;
        push(1, 16'h1111);
        push(1, 16'h2222);
        refresh();
        drain("early");
        check_hist("early", 32'b11);
        push(2, 16'h3333);
        push(0, 16'h4444);
        refresh();
        drain("early_next");
    endtask

    initial begin
        hist_port = 0;
        hist = '0;
        test_reset();
        test_reset_mid_burst();
        test_single_source();
        test_fairness();
        test_backpressure();
        test_wrap();
        test_drain_early();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
